// File: rtl/multicycle_control_unit.sv
// Registered multi-cycle controller for the toy RISC-V core: sequences fetch/decode/execute/
// memory/writeback/trap, generates byte-lane masks, checks alignment and times out memory waits.
package riscv_pkg;
  typedef enum logic [2:0] {
    R_TYPE,
    I_TYPE,
    S_TYPE,
    B_TYPE,
    U_TYPE,
    J_TYPE,
    UNKNOWN_TYPE
  } instruction_type_e;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
endpackage

module multicycle_control_unit
  import riscv_pkg::*;
#(
  parameter  int unsigned XLEN        = 32,
  parameter  int unsigned MEM_TIMEOUT = 15,
  localparam int unsigned MW          = XLEN / 8,
  localparam int unsigned OW          = $clog2(MW)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  instruction_type_e inst_type_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [OW-1:0]     addr_lsb_i,
  input  logic              branch_taken_i,
  input  logic              imem_ready_i,
  input  logic              dmem_ready_i,
  output logic [2:0]        state_o,
  output logic              imem_req_o,
  output logic              ir_write_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [MW-1:0]     mem_write_mask_o,
  output logic              reg_write_o,
  output logic              mem_to_reg_o,
  output logic              pc_write_o,
  output logic [1:0]        pc_sel_o,
  output logic              trap_o,
  output logic [1:0]        trap_cause_o,
  output logic              instret_o
);

  localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int unsigned TW = MW + 8;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [CW-1:0] r_wait_cnt;
  logic [1:0]    r_trap_cause;
  logic [1:0]    w_trap_cause_next;
  logic          w_waiting;

  logic          w_is_load;
  logic          w_is_store;
  logic          w_is_jalr;
  logic          w_is_jal;
  logic          w_is_mem;
  logic [1:0]    w_size;
  logic [3:0]    w_nbytes;
  logic          w_size_illegal;
  logic [OW-1:0] w_align_mask;
  logic          w_misaligned;
  logic [MW-1:0] w_lane_mask;
  logic          w_cnt_at_max;
  logic          w_unused_f3;

  assign w_size         = funct3_i[1:0];
  assign w_unused_f3    = funct3_i[2];
  assign w_is_load      = (inst_type_i == I_TYPE) && (opcode_i == OP_LOAD);
  assign w_is_jalr      = (inst_type_i == I_TYPE) && (opcode_i == OP_JALR);
  assign w_is_store     = (inst_type_i == S_TYPE);
  assign w_is_jal       = (inst_type_i == J_TYPE);
  assign w_is_mem       = w_is_load || w_is_store;
  assign w_size_illegal = w_is_mem && (w_size == 2'b11) && (XLEN != 64);
  assign w_nbytes       = 4'd1 << w_size;
  assign w_align_mask   = OW'(w_nbytes - 4'd1);
  assign w_misaligned   = (addr_lsb_i & w_align_mask) != '0;
  // Lanes built in a wider field so a shifted mask is truncated, not wrapped.
  assign w_lane_mask    = MW'(((TW'(1) << w_nbytes) - TW'(1)) << addr_lsb_i);
  assign w_cnt_at_max   = (MEM_TIMEOUT != 0) && (r_wait_cnt == CW'(MEM_TIMEOUT));

  assign state_o      = r_state;
  assign trap_cause_o = r_trap_cause;

  always_comb begin
    w_state_next      = r_state;
    w_trap_cause_next = r_trap_cause;
    w_waiting         = 1'b0;
    imem_req_o        = 1'b0;
    ir_write_o        = 1'b0;
    dmem_req_o        = 1'b0;
    dmem_we_o         = 1'b0;
    mem_write_mask_o  = '0;
    reg_write_o       = 1'b0;
    mem_to_reg_o      = 1'b0;
    pc_write_o        = 1'b0;
    pc_sel_o          = 2'b00;
    trap_o            = 1'b0;
    instret_o         = 1'b0;

    case (r_state)
      S_FETCH: begin
        // Reset parks the FSM here, so the request is gated by reset itself.
        imem_req_o = rst_ni;
        if (imem_ready_i) begin
          ir_write_o   = rst_ni;
          w_state_next = S_DECODE;
        end else if (w_cnt_at_max) begin
          w_state_next      = S_TRAP;
          w_trap_cause_next = 2'b10;
        end else begin
          w_waiting = 1'b1;
        end
      end
      S_DECODE: begin
        if ((inst_type_i == UNKNOWN_TYPE) || w_size_illegal) begin
          w_state_next      = S_TRAP;
          w_trap_cause_next = 2'b00;
        end else begin
          w_state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (inst_type_i == B_TYPE) begin
          pc_write_o   = 1'b1;
          instret_o    = 1'b1;
          pc_sel_o     = branch_taken_i ? 2'b01 : 2'b00;
          w_state_next = S_FETCH;
        end else if (w_is_mem) begin
          if (w_misaligned) begin
            w_state_next      = S_TRAP;
            w_trap_cause_next = 2'b01;
          end else begin
            w_state_next = S_MEM;
          end
        end else begin
          w_state_next = S_WRITEBACK;
        end
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = w_is_store;
        if (w_is_store) begin
          mem_write_mask_o = w_lane_mask;
        end
        if (dmem_ready_i) begin
          if (w_is_store) begin
            pc_write_o   = 1'b1;
            instret_o    = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WRITEBACK;
          end
        end else if (w_cnt_at_max) begin
          w_state_next      = S_TRAP;
          w_trap_cause_next = 2'b11;
        end else begin
          w_waiting = 1'b1;
        end
      end
      S_WRITEBACK: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = w_is_load;
        pc_write_o   = 1'b1;
        instret_o    = 1'b1;
        if (w_is_jal) begin
          pc_sel_o = 2'b01;
        end else if (w_is_jalr) begin
          pc_sel_o = 2'b10;
        end
        w_state_next = S_FETCH;
      end
      S_TRAP: begin
        trap_o       = 1'b1;
        pc_write_o   = 1'b1;
        pc_sel_o     = 2'b11;
        w_state_next = S_FETCH;
      end
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_FETCH;
      r_wait_cnt   <= '0;
      r_trap_cause <= 2'b00;
    end else begin
      r_state      <= w_state_next;
      r_trap_cause <= w_trap_cause_next;
      // Counter saturates at MEM_TIMEOUT; with MEM_TIMEOUT=0 it never leaves zero.
      if ((w_state_next != r_state) &&
          ((w_state_next == S_FETCH) || (w_state_next == S_MEM))) begin
        r_wait_cnt <= '0;
      end else if (w_waiting && (r_wait_cnt != CW'(MEM_TIMEOUT))) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: vector table, hand sequences and random instructions
// compared cycle by cycle against a per-instruction trace model.
module tb_multicycle_control_unit;
  import riscv_pkg::*;

  localparam logic [6:0] OP_OPR = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_ST  = 7'b0100011;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       ir_write;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] mask;
    logic       reg_write;
    logic       mem_to_reg;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       trap;
    logic [1:0] cause;
    logic       instret;
  } outs_t;

  typedef struct {
    logic  imr;
    logic  dmr;
    outs_t exp;
  } cyc_t;

  typedef struct {
    instruction_type_e ty;
    logic [6:0]        op;
    logic [2:0]        f3;
    logic [2:0]        lsb;
    logic              br;
    int unsigned       iw;
    int unsigned       dw;
  } instr_t;

  typedef struct {
    int          dut;
    instr_t      in;
    int          lat;
    logic [1:0]  cause;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n [2];
  instruction_type_e ty    [2];
  logic [6:0]        op    [2];
  logic [2:0]        f3    [2];
  logic              br    [2];
  logic              imr   [2];
  logic              dmr   [2];
  logic [1:0]        lsb0;
  logic [2:0]        lsb1;

  logic [2:0] st   [2];
  logic       imq  [2];
  logic       irw  [2];
  logic       dreq [2];
  logic       dwe  [2];
  logic       rw   [2];
  logic       m2r  [2];
  logic       pcw  [2];
  logic [1:0] psel [2];
  logic       trp  [2];
  logic [1:0] cse  [2];
  logic       ir   [2];
  logic [3:0] m0;
  logic [7:0] m1;

  multicycle_control_unit #(.XLEN(32), .MEM_TIMEOUT(3)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n[0]), .inst_type_i(ty[0]), .opcode_i(op[0]), .funct3_i(f3[0]),
    .addr_lsb_i(lsb0), .branch_taken_i(br[0]), .imem_ready_i(imr[0]), .dmem_ready_i(dmr[0]),
    .state_o(st[0]), .imem_req_o(imq[0]), .ir_write_o(irw[0]), .dmem_req_o(dreq[0]),
    .dmem_we_o(dwe[0]), .mem_write_mask_o(m0), .reg_write_o(rw[0]), .mem_to_reg_o(m2r[0]),
    .pc_write_o(pcw[0]), .pc_sel_o(psel[0]), .trap_o(trp[0]), .trap_cause_o(cse[0]),
    .instret_o(ir[0])
  );

  multicycle_control_unit #(.XLEN(64), .MEM_TIMEOUT(0)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n[1]), .inst_type_i(ty[1]), .opcode_i(op[1]), .funct3_i(f3[1]),
    .addr_lsb_i(lsb1), .branch_taken_i(br[1]), .imem_ready_i(imr[1]), .dmem_ready_i(dmr[1]),
    .state_o(st[1]), .imem_req_o(imq[1]), .ir_write_o(irw[1]), .dmem_req_o(dreq[1]),
    .dmem_we_o(dwe[1]), .mem_write_mask_o(m1), .reg_write_o(rw[1]), .mem_to_reg_o(m2r[1]),
    .pc_write_o(pcw[1]), .pc_sel_o(psel[1]), .trap_o(trp[1]), .trap_cause_o(cse[1]),
    .instret_o(ir[1])
  );

  int         checks = 0;
  int         errors = 0;
  int         xl     [2] = '{32, 64};
  int         tmo    [2] = '{3, 0};
  logic [1:0] mcause [2];
  bit         g_noise;
  cyc_t       trace  [$];
  vec_t       vecs   [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic outs_t get(input int d);
    outs_t o;
    o.st = st[d];   o.imem_req = imq[d]; o.ir_write = irw[d]; o.dmem_req = dreq[d];
    o.dmem_we = dwe[d]; o.mask = (d == 0) ? {4'b0, m0} : m1;
    o.reg_write = rw[d]; o.mem_to_reg = m2r[d]; o.pc_write = pcw[d]; o.pc_sel = psel[d];
    o.trap = trp[d]; o.cause = cse[d]; o.instret = ir[d];
    return o;
  endfunction

  function automatic logic rnd();
    return g_noise ? logic'($urandom_range(0, 1)) : 1'b0;
  endfunction

  function automatic outs_t base(input logic [2:0] s, input logic [1:0] c);
    outs_t o = '0;
    o.st = s;
    o.cause = c;
    return o;
  endfunction

  function automatic void push(input logic i, input logic dm, input outs_t o);
    cyc_t c;
    c.imr = i; c.dmr = dm; c.exp = o;
    trace.push_back(c);
  endfunction

  function automatic void take_trap(input int d, input logic [1:0] c);
    outs_t o;
    mcause[d] = c;
    o = base(3'd5, c);
    o.trap = 1'b1; o.pc_write = 1'b1; o.pc_sel = 2'b11;
    push(rnd(), rnd(), o);
  endfunction

  // Expected cycle-by-cycle trace of one instruction, from the architectural rules.
  function automatic void gen(input instr_t in, input int d);
    outs_t       o;
    int unsigned mw   = xl[d] / 8;
    int unsigned lsb  = in.lsb % mw;
    int unsigned nb   = 1 << in.f3[1:0];
    bit          ld   = (in.ty == I_TYPE) && (in.op == OP_LOAD);
    bit          sto  = (in.ty == S_TYPE);
    bit          jalr = (in.ty == I_TYPE) && (in.op == OP_JALR);
    bit          bad  = (in.ty == UNKNOWN_TYPE) || ((ld || sto) && nb == 8 && xl[d] != 64);
    trace.delete();
    for (int unsigned c = 0; c <= in.iw; c++) begin
      o = base(3'd0, mcause[d]);
      o.imem_req = 1'b1;
      if (c == in.iw) begin
        o.ir_write = 1'b1;
        push(1'b1, rnd(), o);
      end else begin
        push(1'b0, rnd(), o);
        if (tmo[d] != 0 && c == tmo[d]) begin take_trap(d, 2'b10); return; end
      end
    end
    push(rnd(), rnd(), base(3'd1, mcause[d]));
    if (bad) begin take_trap(d, 2'b00); return; end
    o = base(3'd2, mcause[d]);
    if (in.ty == B_TYPE) begin
      o.pc_write = 1'b1; o.instret = 1'b1; o.pc_sel = in.br ? 2'b01 : 2'b00;
      push(rnd(), rnd(), o);
      return;
    end
    push(rnd(), rnd(), o);
    if (ld || sto) begin
      if (lsb % nb != 0) begin take_trap(d, 2'b01); return; end
      for (int unsigned c = 0; c <= in.dw; c++) begin
        o = base(3'd3, mcause[d]);
        o.dmem_req = 1'b1; o.dmem_we = sto;
        if (sto) o.mask = 8'((((1 << nb) - 1) << lsb) & ((1 << mw) - 1));
        if (c == in.dw) begin
          if (sto) begin o.pc_write = 1'b1; o.instret = 1'b1; end
          push(rnd(), 1'b1, o);
          if (sto) return;
        end else begin
          push(rnd(), 1'b0, o);
          if (tmo[d] != 0 && c == tmo[d]) begin take_trap(d, 2'b11); return; end
        end
      end
    end
    o = base(3'd4, mcause[d]);
    o.reg_write = 1'b1; o.mem_to_reg = ld; o.pc_write = 1'b1; o.instret = 1'b1;
    o.pc_sel = (in.ty == J_TYPE) ? 2'b01 : (jalr ? 2'b10 : 2'b00);
    push(rnd(), rnd(), o);
  endfunction

  task automatic run(input int d, input instr_t in, output int lat, output logic [1:0] cause);
    outs_t a;
    gen(in, d);
    lat = 0;
    cause = 2'bxx;
    foreach (trace[i]) begin
      @(negedge clk);
      if (i == 0) begin
        ty[d] = in.ty; op[d] = in.op; f3[d] = in.f3; br[d] = in.br;
        if (d == 0) lsb0 = in.lsb[1:0];
        else        lsb1 = in.lsb;
      end
      imr[d] = trace[i].imr;
      dmr[d] = trace[i].dmr;
      #1;
      a = get(d);
      check($sformatf("d%0d_cyc%0d_%s", d, i, in.ty.name()), 32'(a), 32'(trace[i].exp));
      if (lat == 0 && (a.instret || a.trap)) lat = i + 1;
      cause = a.cause;
    end
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    rst_n[d] = 1'b0; imr[d] = 1'b1; dmr[d] = 1'b1;
    #1;
    check($sformatf("d%0d_reset_outputs", d), 32'(get(d)), 32'(0));
    @(posedge clk);
    #2;
    imr[d] = 1'b0; dmr[d] = 1'b0; mcause[d] = 2'b00;
    rst_n[d] = 1'b1;
  endtask

  function automatic instr_t mk(input instruction_type_e t, input logic [6:0] o,
                                input logic [2:0] f, input logic [2:0] l, input logic b,
                                input int unsigned iw, input int unsigned dw);
    instr_t r;
    r.ty = t; r.op = o; r.f3 = f; r.lsb = l; r.br = b; r.iw = iw; r.dw = dw;
    return r;
  endfunction

  function automatic void add(input int d, input instr_t in, input int lat, input logic [1:0] c);
    vec_t v;
    v.dut = d; v.in = in; v.lat = lat; v.cause = c;
    vecs.push_back(v);
  endfunction

  function automatic instr_t rand_instr();
    logic [6:0] o;
    case ($urandom_range(0, 3))
      0:       o = OP_LOAD;
      1:       o = OP_JALR;
      2:       o = OP_IMM;
      default: o = 7'($urandom);
    endcase
    return mk(instruction_type_e'($urandom_range(0, 6)), o, 3'($urandom), 3'($urandom),
              1'($urandom), $urandom_range(0, 5), $urandom_range(0, 5));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int         lat;
    logic [1:0] c;
    bit         d1_up = 1'b0;

    add(0, mk(R_TYPE,       OP_OPR,  3'd0, 3'd0, 0, 0, 0), 4, 2'd0);
    add(0, mk(S_TYPE,       OP_ST,   3'd1, 3'd2, 0, 0, 3), 7, 2'd0);
    add(0, mk(S_TYPE,       OP_ST,   3'd0, 3'd3, 0, 0, 0), 4, 2'd0);
    add(0, mk(S_TYPE,       OP_ST,   3'd2, 3'd2, 0, 0, 0), 4, 2'd1);
    add(0, mk(I_TYPE,       OP_LOAD, 3'd3, 3'd0, 0, 0, 0), 3, 2'd0);
    add(0, mk(B_TYPE,       OP_BR,   3'd0, 3'd0, 1, 0, 0), 3, 2'd0);
    add(0, mk(B_TYPE,       OP_BR,   3'd0, 3'd0, 0, 0, 0), 3, 2'd0);
    add(0, mk(I_TYPE,       OP_JALR, 3'd0, 3'd0, 0, 0, 0), 4, 2'd0);
    add(0, mk(I_TYPE,       OP_LOAD, 3'd2, 3'd0, 0, 0, 5), 8, 2'd3);
    add(0, mk(I_TYPE,       OP_LOAD, 3'd2, 3'd0, 0, 0, 3), 8, 2'd3);
    add(0, mk(U_TYPE,       OP_LUI,  3'd0, 3'd0, 0, 5, 0), 5, 2'd2);
    add(0, mk(J_TYPE,       OP_JAL,  3'd0, 3'd0, 0, 2, 0), 6, 2'd2);
    add(0, mk(UNKNOWN_TYPE, OP_OPR,  3'd0, 3'd0, 0, 0, 0), 3, 2'd0);
    add(0, mk(I_TYPE,       OP_LOAD, 3'd2, 3'd0, 0, 0, 0), 5, 2'd0);
    add(0, mk(I_TYPE,       OP_IMM,  3'd3, 3'd1, 0, 0, 0), 4, 2'd0);
    add(1, mk(S_TYPE,       OP_ST,   3'd3, 3'd0, 0, 0, 0), 4, 2'd0);
    add(1, mk(I_TYPE,       OP_LOAD, 3'd3, 3'd4, 0, 0, 0), 4, 2'd1);
    add(1, mk(I_TYPE,       OP_LOAD, 3'd2, 3'd4, 0, 0, 20), 25, 2'd1);
    add(1, mk(U_TYPE,       OP_LUI,  3'd0, 3'd0, 0, 20, 0), 24, 2'd1);
    add(1, mk(S_TYPE,       OP_ST,   3'd1, 3'd7, 0, 0, 0), 4, 2'd1);
    add(1, mk(S_TYPE,       OP_ST,   3'd2, 3'd4, 0, 0, 0), 4, 2'd1);

    rst_n = '{1'b0, 1'b0};
    ty = '{R_TYPE, R_TYPE}; op = '{7'd0, 7'd0}; f3 = '{3'd0, 3'd0}; br = '{1'b0, 1'b0};
    imr = '{1'b0, 1'b0}; dmr = '{1'b0, 1'b0}; lsb0 = '0; lsb1 = '0;
    mcause = '{2'd0, 2'd0};
    g_noise = 1'b0;

    do_reset(0);
    foreach (vecs[k]) begin
      if (vecs[k].dut == 1 && !d1_up) begin
        g_noise = 1'b1;
        for (int n = 0; n < 150; n++) run(0, rand_instr(), lat, c);
        g_noise = 1'b0;
        do_reset(1);
        d1_up = 1'b1;
      end
      run(vecs[k].dut, vecs[k].in, lat, c);
      check($sformatf("vec%0d_latency", k), 32'(lat), 32'(vecs[k].lat));
      check($sformatf("vec%0d_cause", k), 32'(c), 32'(vecs[k].cause));
    end

    g_noise = 1'b1;
    for (int n = 0; n < 150; n++) run(1, rand_instr(), lat, c);
    g_noise = 1'b0;

    // Reset asserted while a load waits in MEM.
    @(negedge clk);
    ty[1] = I_TYPE; op[1] = OP_LOAD; f3[1] = 3'd2; lsb1 = 3'd0; imr[1] = 1'b1; dmr[1] = 1'b0;
    #1 check("abort_fetch_state", 32'(st[1]), 32'd0);
    @(negedge clk); imr[1] = 1'b0;
    #1 check("abort_decode_state", 32'(st[1]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1 check("abort_mem_req", 32'({st[1], dreq[1]}), 32'({3'd3, 1'b1}));
    @(negedge clk);
    #1 rst_n[1] = 1'b0;
    #1 check("abort_outputs_zero", 32'(get(1)), 32'(0));
    dmr[1] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      #1 check($sformatf("abort_hold%0d", n), 32'({st[1], rw[1], ir[1]}), 32'(0));
    end
    @(posedge clk);
    #2;
    dmr[1] = 1'b0; mcause[1] = 2'b00; rst_n[1] = 1'b1;
    run(1, mk(R_TYPE, OP_OPR, 3'd0, 3'd0, 0, 0, 0), lat, c);
    check("restart_latency", 32'(lat), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
